dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the MIPS core: the memory end of the core's data-bus request interface (`memread`/`memwrite`/`address`/`writedata` in, `readdata` back).
- Unlike the single-cycle memory, it models a wait-stated memory.
- It accepts one request at a time, holds it for a programmable number of wait cycles, then commits the write or returns read data with a one-cycle `ready` pulse.
- It lets the core, and later a multi-cycle datapath, be tested against non-zero-latency memory.

## Interface
- `DEPTH_WORDS`, 256, number of 32-bit words stored; power of two, ≥ 2.
- `WAIT_CYCLES`, 2, wait states between acceptance and completion; 0 to 15.
- `clock`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `memread`  in  1  read request; held high by the core until `ready`.
- `memwrite`  in  1  write request; held high by the core until `ready`.
- `address`  in  32  byte address; bits [1:0] must be 00.
- `writedata`  in  32  write data, sampled at acceptance.
- `readdata`  out  32  read data, registered.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while a request is accepted but not completed.
- `err`  out  1  valid only with `ready`; request was illegal and had no effect.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **IDLE:**
  - `memread | memwrite` high at a clock edge means the request is accepted.
  - At acceptance, latch op, word index, `writedata`, and the error condition.
  - Next state is WAIT when `WAIT_CYCLES > 0`, otherwise DONE.
  - The wait counter loads `WAIT_CYCLES - 1`.
- **WAIT:**
  - Counter decrements each cycle.
  - On the edge where the counter is 0, go to DONE.
  - The same edge commits the write or registers `readdata`.
  - With `WAIT_CYCLES = 0`, the commit happens on the IDLE→DONE edge instead.
- **DONE:**
  - `ready = 1` for exactly this cycle; `err` is valid.
  - Unconditional return to IDLE.
  - Requests are not sampled in DONE; the core must drop its request in the cycle after `ready`.
- **Word index:** `address[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- **Error condition** (`address[1:0] != 0`, or `memread & memwrite` both high):
  - No array write.
  - `readdata` becomes 0.
  - `err = 1` with `ready`, at normal latency.
- `readdata` updates only on read completion (value or 0 on error). It holds otherwise, including across writes.
- `busy` is high in WAIT, and in DONE.
- Request inputs changing during WAIT or DONE are ignored; only latched values are used.

## Timing
- Acceptance at the edge ending cycle n puts `ready` high in cycle n+1+`WAIT_CYCLES`.
- Minimum request-to-request spacing is `WAIT_CYCLES + 2` cycles: the next acceptance can be no earlier than the cycle after DONE.
- Read data is valid in the `ready` cycle and stays stable afterwards until the next read completion.
- A write is visible to a read accepted in the cycle after its DONE.
- **Reset values:** state IDLE, counter 0, `ready` 0, `busy` 0, `err` 0, `readdata` 0.
- The storage array is not reset; its contents survive `Reset`.
- **Reset mid-operation** (in WAIT or DONE): return to IDLE next cycle, the pending write is discarded, and no `ready` pulse is issued.
- `Reset` outranks an acceptance on the same edge.

## Structure
- Shared package `mips_pkg`: `WORD_W = 32` and the state enumeration type (`DMR_IDLE`, `DMR_WAIT`, `DMR_DONE`).
- One sub-module, `dmem_array`:
  - `DEPTH_WORDS` × 32 storage.
  - Synchronous write with write enable.
  - Asynchronous read.
  - No reset.
- `dmem_responder` holds the FSM, wait counter, request latches, error decode and the `readdata` register.

## Test plan
- Reset, then write `0xDEADBEEF` to `0x00000010`, then read `0x00000010`, with `WAIT_CYCLES = 2` → each `ready` pulse is 3 cycles after acceptance; `readdata = 0xDEADBEEF`; `err = 0`.
- `WAIT_CYCLES = 0`: write `0x12345678` to `0x4`, then read `0x4` → `ready` in the cycle after acceptance; read returns `0x12345678`.
- Read `0x00000006` (misaligned) after storing `0xAAAA5555` at `0x4` → `ready` with `err = 1`, `readdata = 0`; a following read of `0x4` still returns `0xAAAA5555`.
- `DEPTH_WORDS = 256`: write `0xCAFEF00D` to `0x400`, then read `0x0` → `0xCAFEF00D` (wrap); assert `memread` and `memwrite` together → `err = 1` and no write.
- Accept write `0x11111111` to `0x8`, assert `Reset` during WAIT → no `ready`, `busy = 0` next cycle; a subsequent read of `0x8` returns the prior contents, not `0x11111111`.
- Change `address` and `writedata` during WAIT → committed values equal those latched at acceptance; a request held through DONE is not re-accepted until IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core and its memory-side blocks.
package mips_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_DONE = 2'd2
  } dmr_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-wide data storage: synchronous write, asynchronous read, no reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data memory: accepts one request, waits WAIT_CYCLES, then
// commits the write or returns read data alongside a one-cycle ready pulse.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              Reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [WORD_W-1:0] address,
  input  logic [WORD_W-1:0] writedata,
  output logic [WORD_W-1:0] readdata,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);

  dmr_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              op_rd;
  logic              op_wr;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;

  logic              accept_c;
  logic              direct_c;
  logic              commit_c;
  logic              err_dec_c;
  logic              c_rd;
  logic              c_wr;
  logic              c_err;
  logic [AW-1:0]     c_idx;
  logic [WORD_W-1:0] c_wdata;
  logic              we_c;
  logic [WORD_W-1:0] rdata_c;
  logic              unused_addr_bits;

  // Upper address bits are deliberately ignored so addresses wrap.
  assign unused_addr_bits = ^address[WORD_W-1:AW+2];

  assign err_dec_c = (address[1:0] != 2'b00) || (memread && memwrite);
  assign accept_c  = (state == DMR_IDLE) && (memread || memwrite);

  // With no wait states the commit uses the live request on the accept edge.
  assign direct_c = ZERO_WAIT && accept_c;
  assign commit_c = direct_c || ((state == DMR_WAIT) && (cnt == '0));
  assign c_rd     = direct_c ? memread   : op_rd;
  assign c_wr     = direct_c ? memwrite  : op_wr;
  assign c_err    = direct_c ? err_dec_c : err_q;
  assign c_idx    = direct_c ? address[AW+1:2] : idx;
  assign c_wdata  = direct_c ? writedata : wdata_q;
  assign we_c     = commit_c && !Reset && c_wr && !c_err;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clock(clock),
    .we   (we_c),
    .waddr(c_idx),
    .wdata(c_wdata),
    .raddr(c_idx),
    .rdata(rdata_c)
  );

  always_ff @(posedge clock) begin
    if (Reset) begin
      state    <= DMR_IDLE;
      cnt      <= '0;
      op_rd    <= 1'b0;
      op_wr    <= 1'b0;
      idx      <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      readdata <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        DMR_IDLE: begin
          if (accept_c) begin
            op_rd   <= memread;
            op_wr   <= memwrite;
            idx     <= address[AW+1:2];
            wdata_q <= writedata;
            err_q   <= err_dec_c;
            cnt     <= CNT_W'(CNT_LOAD);
            busy    <= 1'b1;
            if (ZERO_WAIT) begin
              state <= DMR_DONE;
              ready <= 1'b1;
              err   <= err_dec_c;
            end else begin
              state <= DMR_WAIT;
            end
          end
        end
        DMR_WAIT: begin
          if (cnt == '0) begin
            state <= DMR_DONE;
            ready <= 1'b1;
            err   <= err_q;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DMR_DONE: begin
          state <= DMR_IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= DMR_IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
      // Read data changes only when a read completes; errors return zero.
      if (commit_c && c_rd) begin
        readdata <= c_err ? '0 : rdata_c;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with two wait states and
// one with none, both checked against a word-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        memread   [2];
  logic        memwrite  [2];
  logic [31:0] address   [2];
  logic [31:0] writedata [2];
  logic [31:0] readdata  [2];
  logic        ready     [2];
  logic        busy      [2];
  logic        err       [2];

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_w2 (
    .clock(clk), .Reset(rst[0]), .memread(memread[0]), .memwrite(memwrite[0]),
    .address(address[0]), .writedata(writedata[0]), .readdata(readdata[0]),
    .ready(ready[0]), .busy(busy[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_w0 (
    .clock(clk), .Reset(rst[1]), .memread(memread[1]), .memwrite(memwrite[1]),
    .address(address[1]), .writedata(writedata[1]), .readdata(readdata[1]),
    .ready(ready[1]), .busy(busy[1]), .err(err[1])
  );

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } exp_t;

  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [31:0] mdl     [2][256];
  logic [31:0] last_rd [2];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h at cycle %0d", name, d, act, exp, cyc);
    end
  endtask

  // Issue one request; the model decides the outcome, the monitor checks it.
  task automatic req(input int d, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] wd);
    exp_t       e;
    logic [7:0] idx;
    bit         er;
    int         budget;
    memread[d]   = rd;
    memwrite[d]  = wr;
    address[d]   = a;
    writedata[d] = wd;
    idx = a[9:2];
    er  = (a[1:0] != 2'b00) || (rd && wr);
    if (wr && !er) mdl[d][idx] = wd;
    if (rd) last_rd[d] = er ? 32'h0 : mdl[d][idx];
    e.rd  = last_rd[d];
    e.er  = er;
    e.cyc = cyc + 1 + wait_of(d);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
      // Scramble the bus after acceptance; only latched values may be used.
      address[d]   = $urandom;
      writedata[d] = $urandom;
    end while (!ready[d] && budget < 40);
    if (!ready[d]) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout dut%0d: no ready within %0d cycles", d, budget);
    end
    // Request stays high through the DONE edge, dropped in the following cycle.
    @(negedge clk);
    memread[d]  = 1'b0;
    memwrite[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (ready[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_ready dut%0d: ready with nothing pending at cycle %0d", d, cyc);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check("readdata", d, readdata[d], e.rd);
          check("err", d, 32'(err[d]), 32'(e.er));
          check("ready_cycle", d, 32'(cyc), 32'(e.cyc));
          check("busy_at_ready", d, 32'(busy[d]), 32'h1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      memread[d]   = 1'b0;
      memwrite[d]  = 1'b0;
      address[d]   = 32'h0;
      writedata[d] = 32'h0;
      last_rd[d]   = 32'h0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("rst_readdata", d, readdata[d], 32'h0);
      check("rst_ready", d, 32'(ready[d]), 32'h0);
      check("rst_busy", d, 32'(busy[d]), 32'h0);
      check("rst_err", d, 32'(err[d]), 32'h0);
    end

    for (int d = 0; d < 2; d++) begin
      // Give every word a known value; upper address bits are random.
      for (int i = 0; i < 256; i++) begin
        a = ($urandom & 32'hFFFF_FC00) | 32'(i << 2);
        req(d, 1'b0, 1'b1, a, $urandom);
      end

      req(d, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      req(d, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
      req(d, 1'b0, 1'b1, 32'h0000_0004, 32'hAAAA_5555);
      req(d, 1'b1, 1'b0, 32'h0000_0006, 32'h0);
      req(d, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
      req(d, 1'b0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D);
      req(d, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
      req(d, 1'b1, 1'b1, 32'h0000_0000, 32'h0BAD_BAD0);
      req(d, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
      req(d, 1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678);
      req(d, 1'b1, 1'b0, 32'h0000_0004, 32'h0);

      for (int k = 0; k < 200; k++) begin
        r = $urandom_range(0, 99);
        a = $urandom;
        if (r < 45)      req(d, 1'b1, 1'b0, a & 32'hFFFF_FFFC, 32'h0);
        else if (r < 85) req(d, 1'b0, 1'b1, a & 32'hFFFF_FFFC, $urandom);
        else if (r < 93) begin
          if (a[1:0] == 2'b00) a = a | 32'h1;
          if (r[0]) req(d, 1'b1, 1'b0, a, 32'h0);
          else      req(d, 1'b0, 1'b1, a, $urandom);
        end
        else             req(d, 1'b1, 1'b1, a, $urandom);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    // Reset during the wait of a write: no ready, no commit.
    memread[0]   = 1'b0;
    memwrite[0]  = 1'b1;
    address[0]   = 32'h0000_0008;
    writedata[0] = 32'h1111_1111;
    @(negedge clk);
    check("accepted_busy", 0, 32'(busy[0]), 32'h1);
    rst[0]      = 1'b1;
    memwrite[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    check("midrst_busy", 0, 32'(busy[0]), 32'h0);
    check("midrst_ready", 0, 32'(ready[0]), 32'h0);
    repeat (4) @(negedge clk);
    req(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);

    repeat (5) @(negedge clk);
    check("pending_left", 0, 32'(q0.size() + q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
